// File: rtl/rv_id_ex_stage.sv
// Decode-to-execute stage: operand forwarding, load-use hazard detection and a
// single-entry valid/ready register feeding rv_alu, plus a stall-cycle counter.
package rv_alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_XOR  = 4'd2,
    OP_OR   = 4'd3,
    OP_AND  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9
  } alu_operations_e;
endpackage

module rv_id_ex_stage
  import rv_alu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  alu_operations_e   alu_ctrl_i,
  input  logic [4:0]        rs1_addr_i,
  input  logic [4:0]        rs2_addr_i,
  input  logic              rs1_used_i,
  input  logic              rs2_used_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic              use_imm_i,
  input  logic [4:0]        rd_addr_i,
  input  logic              reg_write_i,
  input  logic [4:0]        ex_mem_rd_i,
  input  logic              ex_mem_reg_write_i,
  input  logic              ex_mem_is_load_i,
  input  logic [XLEN-1:0]   ex_mem_result_i,
  input  logic [4:0]        mem_wb_rd_i,
  input  logic              mem_wb_reg_write_i,
  input  logic [XLEN-1:0]   mem_wb_result_i,
  output logic              valid_o,
  input  logic              ready_i,
  output alu_operations_e   alu_ctrl_o,
  output logic [XLEN-1:0]   operand_a_o,
  output logic [XLEN-1:0]   operand_b_o,
  output logic [XLEN-1:0]   store_data_o,
  output logic [4:0]        rd_addr_o,
  output logic              reg_write_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic            ex_fwd_ok;
  logic            wb_fwd_ok;
  logic            ex_rs1_hit;
  logic            ex_rs2_hit;
  logic            wb_rs1_hit;
  logic            wb_rs2_hit;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic [XLEN-1:0] op_b;
  logic            hz;
  logic            in_xfer;
  logic            out_xfer;

  // x0 is excluded once here so every per-source match below inherits it.
  assign ex_fwd_ok  = ex_mem_reg_write_i && (ex_mem_rd_i != 5'd0);
  assign wb_fwd_ok  = mem_wb_reg_write_i && (mem_wb_rd_i != 5'd0);
  assign ex_rs1_hit = ex_fwd_ok && (ex_mem_rd_i == rs1_addr_i);
  assign ex_rs2_hit = ex_fwd_ok && (ex_mem_rd_i == rs2_addr_i);
  assign wb_rs1_hit = wb_fwd_ok && (mem_wb_rd_i == rs1_addr_i);
  assign wb_rs2_hit = wb_fwd_ok && (mem_wb_rd_i == rs2_addr_i);

  always_comb begin
    rs1_fwd = rs1_data_i;
    if (ex_rs1_hit && !ex_mem_is_load_i) begin
      rs1_fwd = ex_mem_result_i;
    end else if (wb_rs1_hit) begin
      rs1_fwd = mem_wb_result_i;
    end
  end

  always_comb begin
    rs2_fwd = rs2_data_i;
    if (ex_rs2_hit && !ex_mem_is_load_i) begin
      rs2_fwd = ex_mem_result_i;
    end else if (wb_rs2_hit) begin
      rs2_fwd = mem_wb_result_i;
    end
  end

  assign op_b = use_imm_i ? imm_i : rs2_fwd;

  assign hz = valid_i && ex_mem_is_load_i && ex_fwd_ok &&
              ((rs1_used_i && ex_rs1_hit) || (rs2_used_i && ex_rs2_hit));

  assign ready_o  = (!valid_o || ready_i) && !hz;
  assign in_xfer  = valid_i && ready_o;
  assign out_xfer = valid_o && ready_i;

  // Flush only clears valid; data may still load since it is don't-care then.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o <= 1'b0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
    end else if (in_xfer) begin
      valid_o <= 1'b1;
    end else if (out_xfer) begin
      valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alu_ctrl_o   <= OP_ADD;
      operand_a_o  <= '0;
      operand_b_o  <= '0;
      store_data_o <= '0;
      rd_addr_o    <= '0;
      reg_write_o  <= 1'b0;
    end else if (in_xfer) begin
      alu_ctrl_o   <= alu_ctrl_i;
      operand_a_o  <= rs1_fwd;
      operand_b_o  <= op_b;
      store_data_o <= rs2_fwd;
      rd_addr_o    <= rd_addr_i;
      reg_write_o  <= reg_write_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_o <= '0;
    end else if (hz && !flush_i && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rv_id_ex_stage.sv
// Scoreboard bench for rv_id_ex_stage: expected results are queued on input
// transfer and compared on output transfer; a CNT_W=4 instance checks saturation.
module tb_rv_id_ex_stage;
  import rv_alu_pkg::*;

  localparam int unsigned XLEN = 32;

  typedef struct {
    alu_operations_e op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] st;
    logic [4:0]      rd;
    logic            rw;
  } exp_t;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            flush_i;
  logic            valid_i;
  logic            ready_o;
  alu_operations_e alu_ctrl_i;
  logic [4:0]      rs1_addr_i, rs2_addr_i;
  logic            rs1_used_i, rs2_used_i;
  logic [XLEN-1:0] rs1_data_i, rs2_data_i, imm_i;
  logic            use_imm_i;
  logic [4:0]      rd_addr_i;
  logic            reg_write_i;
  logic [4:0]      ex_mem_rd_i;
  logic            ex_mem_reg_write_i, ex_mem_is_load_i;
  logic [XLEN-1:0] ex_mem_result_i;
  logic [4:0]      mem_wb_rd_i;
  logic            mem_wb_reg_write_i;
  logic [XLEN-1:0] mem_wb_result_i;
  logic            valid_o;
  logic            ready_i;
  alu_operations_e alu_ctrl_o;
  logic [XLEN-1:0] operand_a_o, operand_b_o, store_data_o;
  logic [4:0]      rd_addr_o;
  logic            reg_write_o;
  logic [15:0]     stall_cnt_o;

  logic            s_ready_o, s_valid_o, s_reg_write_o;
  alu_operations_e s_alu_ctrl_o;
  logic [XLEN-1:0] s_operand_a_o, s_operand_b_o, s_store_data_o;
  logic [4:0]      s_rd_addr_o;
  logic [3:0]      s_stall_cnt_o;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  exp_t        q[$];
  exp_t        exp_in;
  int unsigned exp_stall = 0;

  always #5 clk_i = ~clk_i;

  rv_id_ex_stage #(.XLEN(XLEN), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .alu_ctrl_i(alu_ctrl_i), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i), .rs1_data_i(rs1_data_i),
    .rs2_data_i(rs2_data_i), .imm_i(imm_i), .use_imm_i(use_imm_i), .rd_addr_i(rd_addr_i),
    .reg_write_i(reg_write_i), .ex_mem_rd_i(ex_mem_rd_i), .ex_mem_reg_write_i(ex_mem_reg_write_i),
    .ex_mem_is_load_i(ex_mem_is_load_i), .ex_mem_result_i(ex_mem_result_i),
    .mem_wb_rd_i(mem_wb_rd_i), .mem_wb_reg_write_i(mem_wb_reg_write_i),
    .mem_wb_result_i(mem_wb_result_i), .valid_o(valid_o), .ready_i(ready_i),
    .alu_ctrl_o(alu_ctrl_o), .operand_a_o(operand_a_o), .operand_b_o(operand_b_o),
    .store_data_o(store_data_o), .rd_addr_o(rd_addr_o), .reg_write_o(reg_write_o),
    .stall_cnt_o(stall_cnt_o)
  );

  rv_id_ex_stage #(.XLEN(XLEN), .CNT_W(4)) dut_sat (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i), .ready_o(s_ready_o),
    .alu_ctrl_i(alu_ctrl_i), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i), .rs1_data_i(rs1_data_i),
    .rs2_data_i(rs2_data_i), .imm_i(imm_i), .use_imm_i(use_imm_i), .rd_addr_i(rd_addr_i),
    .reg_write_i(reg_write_i), .ex_mem_rd_i(ex_mem_rd_i), .ex_mem_reg_write_i(ex_mem_reg_write_i),
    .ex_mem_is_load_i(ex_mem_is_load_i), .ex_mem_result_i(ex_mem_result_i),
    .mem_wb_rd_i(mem_wb_rd_i), .mem_wb_reg_write_i(mem_wb_reg_write_i),
    .mem_wb_result_i(mem_wb_result_i), .valid_o(s_valid_o), .ready_i(ready_i),
    .alu_ctrl_o(s_alu_ctrl_o), .operand_a_o(s_operand_a_o), .operand_b_o(s_operand_b_o),
    .store_data_o(s_store_data_o), .rd_addr_o(s_rd_addr_o), .reg_write_o(s_reg_write_o),
    .stall_cnt_o(s_stall_cnt_o)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cmp_out(input string tag, input exp_t e);
    check({tag, "_op"}, alu_ctrl_o, e.op);
    check({tag, "_a"},  operand_a_o, e.a);
    check({tag, "_b"},  operand_b_o, e.b);
    check({tag, "_st"}, store_data_o, e.st);
    check({tag, "_rd"}, {rd_addr_o, reg_write_o}, {e.rd, e.rw});
    check({tag, "_sat"}, {s_valid_o, s_alu_ctrl_o, s_operand_a_o, s_operand_b_o, s_store_data_o,
                          s_rd_addr_o, s_reg_write_o}, {1'b1, e.op, e.a, e.b, e.st, e.rd, e.rw});
  endtask

  task automatic set_idle();
    flush_i = 0; valid_i = 0; ready_i = 1; alu_ctrl_i = OP_ADD;
    rs1_addr_i = 5'd1; rs2_addr_i = 5'd2; rs1_used_i = 0; rs2_used_i = 0;
    rs1_data_i = '0; rs2_data_i = '0; imm_i = '0; use_imm_i = 0;
    rd_addr_i = '0; reg_write_i = 0;
    ex_mem_rd_i = '0; ex_mem_reg_write_i = 0; ex_mem_is_load_i = 0; ex_mem_result_i = '0;
    mem_wb_rd_i = '0; mem_wb_reg_write_i = 0; mem_wb_result_i = '0;
  endtask

  task automatic set_exp(input alu_operations_e op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] st, input logic [4:0] rd, input logic rw);
    exp_in.op = op; exp_in.a = a; exp_in.b = b; exp_in.st = st; exp_in.rd = rd; exp_in.rw = rw;
  endtask

  // One clock: scoreboard bookkeeping at the negedge, then settle #1 past posedge.
  task automatic step();
    logic in_x, out_x;
    exp_t e;
    @(negedge clk_i);
    in_x  = valid_i && ready_o;
    out_x = valid_o && ready_i;
    if (out_x) begin
      if (q.size() == 0) check("unexpected_out", 1'b1, 1'b0);
      else begin
        e = q.pop_front();
        cmp_out("out", e);
      end
    end
    if (flush_i) q.delete();
    if (in_x && !flush_i) q.push_back(exp_in);
    @(posedge clk_i);
    #1;
    check("valid_o", valid_o, q.size() != 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    set_idle();
    rst_ni = 0;
    // reset with random inputs
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'($urandom); ready_i = 1'($urandom); flush_i = 1'($urandom);
      rs1_data_i = $urandom; rs2_data_i = $urandom; imm_i = $urandom; use_imm_i = 1'($urandom);
      alu_ctrl_i = alu_operations_e'(4'($urandom_range(9))); rd_addr_i = 5'($urandom);
      reg_write_i = 1; ex_mem_is_load_i = 1'($urandom); ex_mem_reg_write_i = 1;
      ex_mem_rd_i = 5'($urandom); rs1_used_i = 1; rs1_addr_i = ex_mem_rd_i;
      @(posedge clk_i); #1;
      check("rst_valid", valid_o, 1'b0);
      check("rst_op", alu_ctrl_o, OP_ADD);
      check("rst_data", {operand_a_o, operand_b_o, store_data_o, rd_addr_o, reg_write_o}, '0);
      check("rst_cnt", {stall_cnt_o, s_stall_cnt_o}, '0);
    end
    set_idle();
    rst_ni = 1;
    @(posedge clk_i); #1;

    // first instruction after reset
    valid_i = 1; alu_ctrl_i = OP_ADD; rs1_data_i = 5; rs2_data_i = 9; imm_i = 7; use_imm_i = 1;
    rs1_used_i = 1; rd_addr_i = 5'd5; reg_write_i = 1;
    set_exp(OP_ADD, 5, 7, 9, 5'd5, 1);
    step();
    check("first_valid", valid_o, 1'b1);
    check("first_a_b", {operand_a_o, operand_b_o}, {32'd5, 32'd7});

    // forwarding priority on rs1
    alu_ctrl_i = OP_SUB; rs1_addr_i = 5'd3; rs1_data_i = 32'h1111; imm_i = 0;
    ex_mem_rd_i = 5'd3; ex_mem_reg_write_i = 1; ex_mem_result_i = 32'hAAAA;
    mem_wb_rd_i = 5'd3; mem_wb_reg_write_i = 1; mem_wb_result_i = 32'hBBBB;
    set_exp(OP_SUB, 32'hAAAA, 0, 9, 5'd5, 1);
    step();
    ex_mem_reg_write_i = 0;
    set_exp(OP_SUB, 32'hBBBB, 0, 9, 5'd5, 1);
    step();
    rs1_addr_i = 5'd0; ex_mem_rd_i = 0; ex_mem_reg_write_i = 1; mem_wb_rd_i = 0; rs1_data_i = 32'h1234;
    set_exp(OP_SUB, 32'h1234, 0, 9, 5'd5, 1);
    step();
    // rs2 forwarding from EX/MEM into both operand B and store data
    alu_ctrl_i = OP_XOR; rs2_addr_i = 5'd3; use_imm_i = 0; rs2_used_i = 1;
    ex_mem_rd_i = 5'd3; mem_wb_rd_i = 5'd3; rd_addr_i = 5'd7;
    set_exp(OP_XOR, 32'h1234, 32'hAAAA, 32'hAAAA, 5'd7, 1);
    step();

    // load-use hazard
    ex_mem_is_load_i = 1; ex_mem_rd_i = 5'd4; ex_mem_reg_write_i = 1; ex_mem_result_i = 32'hDEAD;
    mem_wb_reg_write_i = 0; rs2_addr_i = 5'd4; rs2_data_i = 32'h99; rs1_addr_i = 5'd1;
    rs1_data_i = 32'h10; alu_ctrl_i = OP_AND; rd_addr_i = 5'd8;
    #1 check("lu_ready", {ready_o, s_ready_o}, 2'b00);
    step();
    exp_stall++;
    check("lu_cnt", stall_cnt_o, exp_stall);
    ex_mem_is_load_i = 0; ex_mem_reg_write_i = 0;
    mem_wb_rd_i = 5'd4; mem_wb_reg_write_i = 1; mem_wb_result_i = 32'h55;
    #1 check("lu_release_ready", ready_o, 1'b1);
    set_exp(OP_AND, 32'h10, 32'h55, 32'h55, 5'd8, 1);
    step();
    check("lu_cnt_hold", stall_cnt_o, exp_stall);
    mem_wb_reg_write_i = 0;

    // back-pressure: held output stays stable, decode sees ready_o=0
    alu_ctrl_i = OP_OR; rs1_data_i = 32'h77; rs2_data_i = 32'h88; rd_addr_i = 5'd9; reg_write_i = 0;
    set_exp(OP_OR, 32'h77, 32'h88, 32'h88, 5'd9, 0);
    step();
    ready_i = 0;
    alu_ctrl_i = OP_SLL; rs1_data_i = 32'hC0; rs2_data_i = 32'hC1; rd_addr_i = 5'd10; reg_write_i = 1;
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_ready", ready_o, 1'b0);
      step();
      if (q.size() != 0) cmp_out("bp_hold", q[0]);
    end
    ready_i = 1;
    set_exp(OP_SLL, 32'hC0, 32'hC1, 32'hC1, 5'd10, 1);
    step();
    check("bp_swap_valid", valid_o, 1'b1);
    check("bp_swap_a", operand_a_o, 32'hC0);

    // flush while holding an instruction and accepting another
    flush_i = 1; alu_ctrl_i = OP_SRA; rs1_data_i = 32'hF0;
    #1 check("fl_ready", ready_o, 1'b1);
    set_exp(OP_SRA, 32'hF0, 32'hC1, 32'hC1, 5'd10, 1);
    step();
    check("fl_valid", valid_o, 1'b0);
    check("fl_cnt", stall_cnt_o, exp_stall);
    // hazard during flush does not count
    ex_mem_is_load_i = 1; ex_mem_reg_write_i = 1; ex_mem_rd_i = 5'd4;
    step();
    check("fl_hz_cnt", stall_cnt_o, exp_stall);

    // saturation: 20 hazard cycles
    flush_i = 0;
    for (int i = 0; i < 20; i++) step();
    exp_stall += 20;
    check("sat_wide", stall_cnt_o, exp_stall);
    check("sat_narrow", s_stall_cnt_o, 4'hF);

    // random traffic with no forwarding and random back-pressure
    set_idle();
    for (int i = 0; i < 80; i++) begin
      valid_i = 1'($urandom); ready_i = ($urandom_range(3) != 0);
      alu_ctrl_i = alu_operations_e'(4'($urandom_range(9)));
      rs1_data_i = $urandom; rs2_data_i = $urandom; imm_i = $urandom; use_imm_i = 1'($urandom);
      rd_addr_i = 5'($urandom); reg_write_i = 1'($urandom);
      set_exp(alu_ctrl_i, rs1_data_i, use_imm_i ? imm_i : rs2_data_i, rs2_data_i, rd_addr_i, reg_write_i);
      step();
    end
    valid_i = 0; ready_i = 1;
    step();
    check("drain_empty", q.size(), 0);
    check("final_cnt", stall_cnt_o, exp_stall);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_id_ex_stage.md
Name: rv_id_ex_stage

Overview:
- Decode-to-execute pipeline stage that directly feeds rv_alu.
- Resolves operand forwarding from EX/MEM and MEM/WB and selects immediate vs. register for operand B.
- Detects load-use hazards and registers the ALU control and operands behind a valid/ready handshake, with flush support.
- Also keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- XLEN, 32, datapath width of operands, immediates and forwarded results.
- CNT_W, 16, width of the stall counter.

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  kill the held instruction and any instruction accepted this cycle
- valid_i  in  1  decode presents an instruction
- ready_o  out  1  stage accepts the instruction this cycle
- alu_ctrl_i  in  alu_operations_e  decoded ALU operation
- rs1_addr_i, rs2_addr_i  in  5 each  source register indices
- rs1_used_i, rs2_used_i  in  1 each  instruction actually reads rs1 / rs2
- rs1_data_i, rs2_data_i  in  XLEN each  register file read data
- imm_i  in  XLEN  sign-extended immediate
- use_imm_i  in  1  operand B = immediate
- rd_addr_i  in  5  destination register
- reg_write_i  in  1  instruction writes rd
- ex_mem_rd_i  in  5  EX/MEM destination
- ex_mem_reg_write_i  in  1  EX/MEM writes rd
- ex_mem_is_load_i  in  1  EX/MEM instruction is a load, result not yet available
- ex_mem_result_i  in  XLEN  EX/MEM ALU result
- mem_wb_rd_i  in  5  MEM/WB destination
- mem_wb_reg_write_i  in  1  MEM/WB writes rd
- mem_wb_result_i  in  XLEN  MEM/WB writeback data
- valid_o  out  1  registered instruction valid toward rv_alu
- ready_i  in  1  execute consumes this cycle
- alu_ctrl_o  out  alu_operations_e  registered ALU operation
- operand_a_o, operand_b_o  out  XLEN each  registered ALU operands
- store_data_o  out  XLEN  registered forwarded rs2 value, regardless of use_imm_i
- rd_addr_o  out  5  registered destination register
- reg_write_o  out  1  registered write enable
- stall_cnt_o  out  CNT_W  count of load-use stall cycles

Behaviour:
- Reset: asynchronous on rst_ni low.
  - valid_o=0, alu_ctrl_o=OP_ADD.
  - operand_a_o, operand_b_o, store_data_o = 0.
  - rd_addr_o=0, reg_write_o=0, stall_cnt_o=0.
  - A transfer in progress at reset is lost.
- Forwarding (combinational, per source N in {1,2}):
  - If ex_mem_reg_write_i, ex_mem_rd_i!=0, ex_mem_rd_i==rsN_addr_i and !ex_mem_is_load_i: use ex_mem_result_i.
  - Otherwise, if mem_wb_reg_write_i, mem_wb_rd_i!=0 and mem_wb_rd_i==rsN_addr_i: use mem_wb_result_i.
  - Otherwise use rsN_data_i.
  - Register x0 is never forwarded. EX/MEM has priority over MEM/WB.
- Operand select:
  - operand A = forwarded rs1.
  - operand B = imm_i if use_imm_i, else forwarded rs2.
  - store data = forwarded rs2.
- Load-use hazard, hz: all of the following hold.
  - valid_i, ex_mem_is_load_i, ex_mem_reg_write_i, ex_mem_rd_i!=0.
  - ((rs1_used_i & rs1 match) | (rs2_used_i & rs2 match)).
- Handshake:
  - ready_o = (!valid_o | ready_i) & !hz.
  - Input transfer when valid_i & ready_o.
  - Output transfer when valid_o & ready_i.
  - Output registers hold stable while valid_o & !ready_i.
- Register update (non-flush cycle):
  - On input transfer: load all output registers and set valid_o=1.
  - Else on output transfer: valid_o=0, data registers hold.
  - Else: no change.
- Flush:
  - flush_i forces valid_o=0 next cycle, overriding any input transfer.
  - ready_o is computed normally, so decode considers the instruction consumed and it is discarded.
  - Data registers may load but are don't-care while valid_o=0.
- Stall counter:
  - Increments by 1 each cycle hz=1 and flush_i=0.
  - Saturates at all-ones and never wraps.
- Latency: one cycle from input transfer to valid_o. Full throughput (one instruction per cycle) when ready_i stays high and no hazard.
- Single-entry stage, so no skid: a stalled output back-pressures decode in the same cycle via ready_o.
- Simultaneous input and output transfer in one cycle: the new instruction replaces the old one and valid_o stays 1.

Test Plan:
- Reset: hold rst_ni=0 with random inputs -> all outputs 0, alu_ctrl_o=OP_ADD. Release, then valid_i=1, OP_ADD, rs1_data=5, imm=7, use_imm=1 -> next cycle valid_o=1, operand_a_o=5, operand_b_o=7.
- Forward priority: rs1=x3; EX/MEM rd=3 result=0xAAAA; MEM/WB rd=3 result=0xBBBB -> operand_a_o=0xAAAA. Drop EX/MEM write -> 0xBBBB. Set rs1=x0 with both rd=0 -> operand_a_o=rs1_data_i.
- Load-use: EX/MEM is_load=1 rd=4; valid_i rs2=x4, rs2_used=1 -> ready_o=0, stall_cnt_o 0->1. Next cycle is_load=0 with MEM/WB rd=4 result=0x55 -> accepted, operand_b_o=0x55 (use_imm=0), store_data_o=0x55.
- Back-pressure: ready_i=0 for 3 cycles with valid_i held -> outputs stable, ready_o=0. ready_i=1 -> next instruction loaded next cycle, valid_o stays 1.
- Flush: valid_o=1 and valid_i=1 with flush_i=1 -> ready_o=1, valid_o=0 next cycle, stall_cnt_o unchanged.
- Saturation: CNT_W=4 with 20 hazard cycles -> stall_cnt_o=15.
